// File: rtl/bn_pkg.sv
// Shared types and constants for the batch-norm statistics path.
// The width localparams describe the default build (H=W=256, FILTERS=64,
// DATA_W=16); modules that take H/W/FILTERS/DATA_W as parameters derive
// their own widths with the same formulas.
package bn_pkg;

  localparam int unsigned BN_H       = 256;
  localparam int unsigned BN_W       = 256;
  localparam int unsigned BN_FILTERS = 64;
  localparam int unsigned BN_DATA_W  = 16;

  localparam int unsigned LOG_N = $clog2(BN_H * BN_W);
  localparam int unsigned CH_W  = $clog2(BN_FILTERS);
  localparam int unsigned SUM_W = BN_DATA_W + LOG_N;
  localparam int unsigned SQ_W  = 2 * BN_DATA_W + LOG_N;

  localparam logic [BN_DATA_W-1:0] VAR_MAX = '1;

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic        [SQ_W-1:0]  sq_t;

  typedef enum logic [1:0] {
    CLEAR,
    ACCUM,
    DRAIN,
    WAIT_ACK
  } state_e;

endpackage

// File: rtl/bn_stat_calc.sv
// Combinational conversion of one channel's accumulators into statistics.
//   sum_i  : signed sum of N = 2**LOG_N samples
//   sq_i   : unsigned sum of squared samples
//   mean_o : floor(sum / N), truncated to DATA_W (always fits)
//   var_o  : E[x^2] - mean^2, clamped to [0, 2**DATA_W-1]
//   sat_o  : either clamp bound was applied
module bn_stat_calc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG_N  = 16
) (
  input  logic signed [DATA_W+LOG_N-1:0]   sum_i,
  input  logic        [2*DATA_W+LOG_N-1:0] sq_i,
  output logic        [DATA_W-1:0]         mean_o,
  output logic        [DATA_W-1:0]         var_o,
  output logic                             sat_o
);
  import bn_pkg::*;

  localparam int unsigned SUM_BITS = DATA_W + LOG_N;
  localparam int unsigned SQ_BITS  = 2 * DATA_W + LOG_N;
  // Wide enough that neither E[x^2] nor mean^2 can wrap before subtraction.
  localparam int unsigned V_BITS   = 2 * SUM_BITS + 1;

  logic signed [SUM_BITS-1:0] mean_full;
  logic        [SQ_BITS-1:0]  ex2;
  logic signed [V_BITS-1:0]   ex2_s;
  logic signed [V_BITS-1:0]   msq_s;
  logic signed [V_BITS-1:0]   v;

  always_comb begin
    mean_full = sum_i >>> LOG_N;
    ex2       = sq_i >> LOG_N;
    ex2_s     = V_BITS'(ex2);
    msq_s     = V_BITS'(mean_full) * V_BITS'(mean_full);
    v         = ex2_s - msq_s;

    mean_o = mean_full[DATA_W-1:0];
    var_o  = v[DATA_W-1:0];
    sat_o  = 1'b0;
    if (v < 0) begin
      var_o = '0;
      sat_o = 1'b1;
    end else if (v[V_BITS-1:DATA_W] != '0) begin
      var_o = '1;
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/bn_stats_accumulator.sv
// Per-channel batch-norm statistics producer.
// Accepts H*W pixels of FILTERS interleaved channels on in_*, then drains
// FILTERS (mean, variance) records on out_*, then re-arms.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_data is the sample of ch_cnt
//   out_valid/out_ready : record handshake
//   out_ch, out_mean, out_var, out_sat, out_last : record fields
module bn_stats_accumulator #(
  parameter int unsigned H       = 256,
  parameter int unsigned W       = 256,
  parameter int unsigned FILTERS = 64,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(FILTERS)-1:0] out_ch,
  output logic [DATA_W-1:0]          out_mean,
  output logic [DATA_W-1:0]          out_var,
  output logic                       out_sat,
  output logic                       out_last
);
  import bn_pkg::*;

  localparam int unsigned N_LOG    = $clog2(H * W);
  localparam int unsigned CH_BITS  = $clog2(FILTERS);
  localparam int unsigned SUM_BITS = DATA_W + N_LOG;
  localparam int unsigned SQ_BITS  = 2 * DATA_W + N_LOG;

  localparam logic [CH_BITS-1:0] CH_LAST  = CH_BITS'(FILTERS - 1);
  localparam logic [N_LOG-1:0]   PIX_LAST = N_LOG'(H * W - 1);

  state_e                     state_q, state_d;
  logic [CH_BITS-1:0]         ch_cnt_q, ch_cnt_d;
  logic [N_LOG-1:0]           pix_cnt_q, pix_cnt_d;
  logic signed [SUM_BITS-1:0] sum_q [FILTERS];
  logic signed [SUM_BITS-1:0] sum_d [FILTERS];
  logic [SQ_BITS-1:0]         sq_q  [FILTERS];
  logic [SQ_BITS-1:0]         sq_d  [FILTERS];

  logic                       out_valid_q, out_valid_d;
  logic [CH_BITS-1:0]         out_ch_q, out_ch_d;
  logic [DATA_W-1:0]          out_mean_q, out_mean_d;
  logic [DATA_W-1:0]          out_var_q, out_var_d;
  logic                       out_sat_q, out_sat_d;
  logic                       out_last_q, out_last_d;

  logic signed [DATA_W-1:0]   in_s;
  logic signed [2*DATA_W-1:0] in_sq;
  logic [DATA_W-1:0]          calc_mean;
  logic [DATA_W-1:0]          calc_var;
  logic                       calc_sat;
  logic                       load;

  assign in_s  = in_data;
  assign in_sq = (2*DATA_W)'(in_s) * (2*DATA_W)'(in_s);

  bn_stat_calc #(
    .DATA_W (DATA_W),
    .LOG_N  (N_LOG)
  ) u_calc (
    .sum_i  (sum_q[ch_cnt_q]),
    .sq_i   (sq_q[ch_cnt_q]),
    .mean_o (calc_mean),
    .var_o  (calc_var),
    .sat_o  (calc_sat)
  );

  assign load = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    sum_d       = sum_q;
    sq_d        = sq_q;
    out_valid_d = out_valid_q;
    out_ch_d    = out_ch_q;
    out_mean_d  = out_mean_q;
    out_var_d   = out_var_q;
    out_sat_d   = out_sat_q;
    out_last_d  = out_last_q;

    unique case (state_q)
      CLEAR: begin
        sum_d[ch_cnt_q] = '0;
        sq_d[ch_cnt_q]  = '0;
        if (ch_cnt_q == CH_LAST) begin
          ch_cnt_d  = '0;
          pix_cnt_d = '0;
          state_d   = ACCUM;
        end else begin
          ch_cnt_d = ch_cnt_q + CH_BITS'(1);
        end
      end

      ACCUM: begin
        if (in_valid) begin
          sum_d[ch_cnt_q] = sum_q[ch_cnt_q] + SUM_BITS'(in_s);
          sq_d[ch_cnt_q]  = sq_q[ch_cnt_q] + SQ_BITS'($unsigned(in_sq));
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            // H*W is a power of two, so pix_cnt wraps back to 0 on its own.
            pix_cnt_d = pix_cnt_q + N_LOG'(1);
            if (pix_cnt_q == PIX_LAST) begin
              state_d = DRAIN;
            end
          end else begin
            ch_cnt_d = ch_cnt_q + CH_BITS'(1);
          end
        end
      end

      DRAIN: begin
        if (load) begin
          out_valid_d     = 1'b1;
          out_ch_d        = ch_cnt_q;
          out_mean_d      = calc_mean;
          out_var_d       = calc_var;
          out_sat_d       = calc_sat;
          out_last_d      = (ch_cnt_q == CH_LAST);
          // Clearing on read leaves the tables ready for the next batch.
          sum_d[ch_cnt_q] = '0;
          sq_d[ch_cnt_q]  = '0;
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d = '0;
            state_d  = WAIT_ACK;
          end else begin
            ch_cnt_d = ch_cnt_q + CH_BITS'(1);
          end
        end
      end

      WAIT_ACK: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      ch_cnt_q    <= '0;
      pix_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_mean_q  <= '0;
      out_var_q   <= '0;
      out_sat_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_mean_q  <= out_mean_d;
      out_var_q   <= out_var_d;
      out_sat_q   <= out_sat_d;
      out_last_q  <= out_last_d;
    end
  end

  // Accumulators need no reset: CLEAR zeroes every channel before use.
  always_ff @(posedge clk) begin
    sum_q <= sum_d;
    sq_q  <= sq_d;
  end

  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = out_valid_q && !rst;
  assign out_ch    = out_ch_q;
  assign out_mean  = out_mean_q;
  assign out_var   = out_var_q;
  assign out_sat   = out_sat_q;
  assign out_last  = out_last_q;

endmodule
